rn_wr_tracker: RTL
==================

RN_WR_TRACKER -- requirements
Module: rn_wr_tracker

Interface
REQ-001 SHALL have parameter DEPTH, default 16: tracker entries, power of two, >=2.
REQ-002 SHALL have parameter ID_W, default 11: AWID width.
REQ-003 SHALL have parameter TGT_W, default 2: target-ID width.
REQ-004 SHALL have parameter LEN_W, default 8: AWLEN width.
REQ-005 SHALL have ports (name  direction  width  meaning):
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- AWVALID  in  1  upstream AW valid
- AWREADY_S  in  1  downstream AW ready
- AWREADY_M  out  1  AW ready to upstream
- AWID  in  ID_W  write ID
- AWLEN  in  LEN_W  beats minus one
- AW_TgtID  in  TGT_W  AW route target
- WVALID  in  1  upstream W valid
- WLAST  in  1  upstream last-beat marker
- WREADY_S  in  1  downstream W ready
- WREADY_M  out  1  W ready to upstream
- W_TgtID  out  TGT_W  route target for current W beat
- W_ID  out  ID_W  AWID owning current W beat
- OUTSTANDING  out  $clog2(DEPTH+1)  stored bursts
- LAST_ERR  out  1  sticky WLAST mismatch flag

Function
REQ-006 aw_hs = AWVALID & AWREADY_M; w_hs = WVALID & WREADY_M.
REQ-007 AWREADY_M = AWREADY_S & (OUTSTANDING != DEPTH); combinational.
REQ-008 On aw_hs, {AWID, AW_TgtID, AWLEN} pushed into in-order FIFO, unless consumed entirely by bypass (REQ-012).
REQ-009 WREADY_M = WREADY_S & (OUTSTANDING != 0 | aw_hs).
REQ-010 Non-empty: W_TgtID/W_ID = head entry fields, no latency.
REQ-011 Empty with aw_hs: W_TgtID/W_ID = AW_TgtID/AWID same cycle (bypass). Empty without aw_hs: both outputs 0.
REQ-012 Bypass with w_hs and AWLEN==0: nothing stored, OUTSTANDING unchanged. Bypass with AWLEN>0: entry stored, beat counter = 1.
REQ-013 Beat counter (LEN_W+1 bits) counts w_hs for head burst. On w_hs where counter == head len, head popped, counter cleared to 0.
REQ-014 Push and pop in same cycle: OUTSTANDING unchanged; pointers both advance, wrapping modulo DEPTH.
REQ-015 Full: aw_hs impossible; W draining continues; AWREADY_M reasserts cycle after pop lowers OUTSTANDING.
REQ-016 On w_hs, WLAST != (counter == head len) sets LAST_ERR; LAST_ERR stays set until reset. Pop timing follows the beat count only, never WLAST.
REQ-017 WVALID without w_hs SHALL not change counter or FIFO.
REQ-018 No combinational path from WVALID to AWREADY_M.

Reset
REQ-019 rst low SHALL asynchronously clear pointers, counter, OUTSTANDING and LAST_ERR to 0. With rst low, AWREADY_M = 0, WREADY_M = 0, W_TgtID = 0, W_ID = 0.
REQ-020 Reset mid-burst SHALL discard all entries. The first cycle after deassertion behaves as empty.
REQ-021 FIFO storage array SHALL need no reset.

Structure
REQ-022 Package rn_pkg SHALL hold default DEPTH/ID_W/TGT_W/LEN_W constants and typedef rn_wr_entry_t {id, tgt, len}.
REQ-023 Storage SHALL be one sub-module, rn_wr_fifo: synchronous FIFO, DEPTH x rn_wr_entry_t, push/pop/full/empty/count.
REQ-024 Bypass, beat counter and error logic SHALL live in rn_wr_tracker.

Verification
REQ-025 Scenario: AW {ID=5, tgt=2, len=3}, then 4 W beats with WLAST on beat 4.
- W_TgtID = 2 and W_ID = 5 on all beats.
- OUTSTANDING goes 1 -> 0 after beat 4.
- LAST_ERR = 0.

REQ-026 Scenario: empty; AW {tgt=1, len=0} and W beat in same cycle.
- W_TgtID = 1 that cycle.
- OUTSTANDING stays 0.

REQ-027 Scenario: 16 AWs with no W traffic.
- AWREADY_M = 0 with AWREADY_S = 1.
- One W beat completing a len=0 head reasserts AWREADY_M next cycle.
- A 17th AW then accepted; wrap correct.

REQ-028 Scenario: AWs tgt 0, 3, 1, each len=1, with interleaved pushes during draining.
- W_TgtID sequence 0, 0, 3, 3, 1, 1.
- Order preserved across simultaneous push/pop.

REQ-029 Scenario: AW len=2, WLAST asserted on beat 2.
- LAST_ERR = 1 from the next cycle.
- Pop still after beat 3.
- LAST_ERR held until rst low.

REQ-030 Scenario: rst low mid-burst with OUTSTANDING = 3.
- All outputs 0 immediately.
- After release, a new AW/W burst routes correctly.

Source files
------------

// File: rtl/rn_pkg.sv
// rn_pkg: default sizes and the stored write-burst entry for the RN write tracker.
package rn_pkg;
   localparam int DEPTH_DEF = 16;
   localparam int ID_W_DEF  = 11;
   localparam int TGT_W_DEF = 2;
   localparam int LEN_W_DEF = 8;
   typedef struct packed {
      logic [ID_W_DEF-1:0]  id;
      logic [TGT_W_DEF-1:0] tgt;
      logic [LEN_W_DEF-1:0] len;
   } rn_wr_entry_t;
endpackage

// File: rtl/rn_wr_fifo.sv
// rn_wr_fifo: in-order burst FIFO with zero-latency head and occupancy count.
module rn_wr_fifo
   import rn_pkg::*;
#(
   parameter int  DEPTH   = DEPTH_DEF,
   parameter type entry_t = rn_wr_entry_t
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  entry_t                     din,
   input  logic                       pop,
   output entry_t                     dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   entry_t        mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   // Power-of-two depth lets the pointers wrap by plain overflow.
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= wr_ptr + AW'(push);
         rd_ptr <= rd_ptr + AW'(pop);
         count  <= count + CW'(push) - CW'(pop);
      end
   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= din;
   assign dout  = mem[rd_ptr];
   assign full  = count == CW'(DEPTH);
   assign empty = count == '0;
endmodule

// File: rtl/rn_wr_tracker.sv
// rn_wr_tracker: tracks accepted AW bursts in order so each W beat is routed to its AW target.
module rn_wr_tracker
   import rn_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int ID_W  = ID_W_DEF,
   parameter int TGT_W = TGT_W_DEF,
   parameter int LEN_W = LEN_W_DEF
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       AWVALID,
   input  logic                       AWREADY_S,
   output logic                       AWREADY_M,
   input  logic [ID_W-1:0]            AWID,
   input  logic [LEN_W-1:0]           AWLEN,
   input  logic [TGT_W-1:0]           AW_TgtID,
   input  logic                       WVALID,
   input  logic                       WLAST,
   input  logic                       WREADY_S,
   output logic                       WREADY_M,
   output logic [TGT_W-1:0]           W_TgtID,
   output logic [ID_W-1:0]            W_ID,
   output logic [$clog2(DEPTH+1)-1:0] OUTSTANDING,
   output logic                       LAST_ERR
);
   typedef struct packed {
      logic [ID_W-1:0]  id;
      logic [TGT_W-1:0] tgt;
      logic [LEN_W-1:0] len;
   } entry_t;
   entry_t           head, aw_ent;
   logic             full, empty, aw_hs, w_hs, push, pop, at_last;
   logic [LEN_W:0]   beat_cnt;
   logic [LEN_W-1:0] cur_len;
   assign aw_ent = '{id: AWID, tgt: AW_TgtID, len: AWLEN};
   // An empty tracker routes W from the AW being accepted this cycle.
   always_comb begin
      AWREADY_M = rst & AWREADY_S & ~full;
      aw_hs     = AWVALID & AWREADY_M;
      WREADY_M  = rst & WREADY_S & (~empty | aw_hs);
      w_hs      = WVALID & WREADY_M;
      cur_len   = empty ? AWLEN : head.len;
      at_last   = beat_cnt == {1'b0, cur_len};
      pop       = w_hs & at_last & ~empty;
      push      = aw_hs & ~(empty & w_hs & AWLEN == '0);
      W_ID      = empty ? (aw_hs ? AWID : '0) : head.id;
      W_TgtID   = empty ? (aw_hs ? AW_TgtID : '0) : head.tgt;
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         beat_cnt <= '0;
         LAST_ERR <= 1'b0;
      end else if (w_hs) begin
         beat_cnt <= at_last ? '0 : beat_cnt + 1'b1;
         LAST_ERR <= LAST_ERR | (WLAST ^ at_last);
      end
   rn_wr_fifo #(.DEPTH(DEPTH), .entry_t(entry_t)) u_fifo (
      .clk  (clk),
      .rst  (rst),
      .push (push),
      .din  (aw_ent),
      .pop  (pop),
      .dout (head),
      .full (full),
      .empty(empty),
      .count(OUTSTANDING)
   );
endmodule
